// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the funct3 size codes, the FSM state encoding and the byte-mask helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;

  // Byte-enable pattern for an access of the given size, before lane shifting.
  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    logic [7:0] m;
    case (funct3[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Steers the addressed field of a read word down to bit 0 and extends it
// to the full datapath width according to the load size/sign code.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [OFFW-1:0] offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] field;

  assign field = rdata >> {offset, 3'b000};

  always_comb begin
    case (funct3)
      F3_B:    result = XLEN'($signed(field[7:0]));
      F3_H:    result = XLEN'($signed(field[15:0]));
      F3_W:    result = XLEN'($signed(field[31:0]));
      F3_BU:   result = XLEN'(field[7:0]);
      F3_HU:   result = XLEN'(field[15:0]);
      F3_WU:   result = XLEN'(field[31:0]);
      default: result = field;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: issues loads/stores to a variable-latency
// data memory, stalls upstream while an access is outstanding, and registers MEM/WB.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int REG_IDX_W       = 5,
  parameter int RESULT_SRC_W    = 2,
  parameter int STORE_WAIT_RESP = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  logic                    ex_mem_read,
  input  logic                    ex_mem_write,
  input  logic [2:0]              ex_funct3,
  input  logic [XLEN-1:0]         ex_alu_result,
  input  logic [XLEN-1:0]         ex_write_data,
  input  logic [REG_IDX_W-1:0]    ex_rd,
  input  logic                    ex_reg_write,
  input  logic [RESULT_SRC_W-1:0] ex_result_src,
  output logic                    stall_m,
  output logic [XLEN-1:0]         alu_result_m,
  output logic                    misaligned_m,
  output logic                    dmem_req_valid,
  input  logic                    dmem_req_ready,
  output logic [XLEN-1:0]         dmem_addr,
  output logic                    dmem_we,
  output logic [XLEN/8-1:0]       dmem_wstrb,
  output logic [XLEN-1:0]         dmem_wdata,
  input  logic                    dmem_resp_valid,
  input  logic [XLEN-1:0]         dmem_rdata,
  output logic                    wb_valid,
  output logic                    wb_reg_write,
  output logic [RESULT_SRC_W-1:0] wb_result_src,
  output logic [REG_IDX_W-1:0]    wb_rd,
  output logic [XLEN-1:0]         wb_alu_result,
  output logic [XLEN-1:0]         wb_read_data
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  mem_state_t                state;
  logic [OFFW-1:0]           op_off;
  logic [2:0]                op_funct3;
  logic [REG_IDX_W-1:0]      op_rd;
  logic                      op_reg_write;
  logic [RESULT_SRC_W-1:0]   op_result_src;
  logic [XLEN-1:0]           op_alu_result;
  logic [XLEN-1:0]           load_result;
  logic [OFFW-1:0]           ex_off;
  logic                      is_mem, is_store, funct3_ok, aligned;
  logic                      take, mem_go, handshake, complete;

  assign alu_result_m = ex_alu_result;
  assign ex_off       = ex_alu_result[OFFW-1:0];
  assign is_mem       = ex_mem_read | ex_mem_write;
  assign is_store     = ex_mem_write & ~ex_mem_read;

  always_comb begin
    case (ex_funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: funct3_ok = 1'b1;
      F3_D, F3_WU:                    funct3_ok = (XLEN == 64);
      default:                        funct3_ok = 1'b0;
    endcase
  end

  // Unsupported size codes fold into the misaligned path.
  always_comb begin
    case (ex_funct3[1:0])
      2'b00:   aligned = funct3_ok;
      2'b01:   aligned = funct3_ok & ~ex_alu_result[0];
      2'b10:   aligned = funct3_ok & (ex_alu_result[1:0] == 2'b00);
      default: aligned = funct3_ok & (ex_alu_result[2:0] == 3'b000);
    endcase
  end

  // DONE also accepts work: stall is low there, so EX/MEM has already moved on.
  assign take      = ex_valid & ((state == IDLE) | (state == DONE));
  assign mem_go    = take & is_mem & aligned;
  assign handshake = (state == REQ) & dmem_req_ready;
  assign complete  = (handshake & ((dmem_we & (STORE_WAIT_RESP == 0)) | dmem_resp_valid))
                   | ((state == WAIT) & dmem_resp_valid);
  assign stall_m   = mem_go | (((state == REQ) | (state == WAIT)) & ~complete);

  load_align #(.XLEN(XLEN), .OFFW(OFFW)) u_load_align (
    .rdata  (dmem_rdata),
    .offset (op_off),
    .funct3 (op_funct3),
    .result (load_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dmem_req_valid <= 1'b0;
      dmem_addr      <= '0;
      dmem_we        <= 1'b0;
      dmem_wstrb     <= '0;
      dmem_wdata     <= '0;
      misaligned_m   <= 1'b0;
      op_off         <= '0;
      op_funct3      <= '0;
      op_rd          <= '0;
      op_reg_write   <= 1'b0;
      op_result_src  <= '0;
      op_alu_result  <= '0;
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_result_src  <= '0;
      wb_rd          <= '0;
      wb_alu_result  <= '0;
      wb_read_data   <= '0;
    end else begin
      wb_valid     <= 1'b0;
      misaligned_m <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (mem_go) begin
            state          <= REQ;
            dmem_req_valid <= 1'b1;
            dmem_addr      <= {ex_alu_result[XLEN-1:OFFW], {OFFW{1'b0}}};
            dmem_we        <= is_store;
            dmem_wstrb     <= is_store ? (NB'(size_mask(ex_funct3)) << ex_off) : '0;
            dmem_wdata     <= is_store ? (ex_write_data << {ex_off, 3'b000}) : '0;
            op_off         <= ex_off;
            op_funct3      <= ex_funct3;
            op_rd          <= ex_rd;
            op_reg_write   <= ex_reg_write;
            op_result_src  <= ex_result_src;
            op_alu_result  <= ex_alu_result;
          end else if (take) begin
            wb_valid      <= 1'b1;
            wb_reg_write  <= ex_reg_write & ~is_mem;
            wb_result_src <= ex_result_src;
            wb_rd         <= ex_rd;
            wb_alu_result <= ex_alu_result;
            wb_read_data  <= '0;
            misaligned_m  <= is_mem;
          end
        end
        REQ: begin
          if (handshake) begin
            dmem_req_valid <= 1'b0;
            state          <= complete ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (dmem_resp_valid) state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (complete) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= op_reg_write;
        wb_result_src <= op_result_src;
        wb_rd         <= op_rd;
        wb_alu_result <= op_alu_result;
        wb_read_data  <= dmem_we ? '0 : load_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a 32-bit instance (stores complete on
// handshake) and a 64-bit instance (stores wait for the response).
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  src;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid32, ex_valid64, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_alu_result, ex_write_data, dmem_rdata;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_result_src;
  logic        dmem_req_ready, dmem_resp_valid;

  logic        s_stall, s_mis, s_rqv, s_we, s_wbv, s_wbrw;
  logic [31:0] s_alu_m, s_addr, s_wdata, s_wbalu, s_wbdata;
  logic [3:0]  s_strb;
  logic [1:0]  s_wbsrc;
  logic [4:0]  s_wbrd;

  logic        d_stall, d_mis, d_rqv, d_we, d_wbv, d_wbrw;
  logic [63:0] d_alu_m, d_addr, d_wdata, d_wbalu, d_wbdata;
  logic [7:0]  d_strb;
  logic [1:0]  d_wbsrc;
  logic [4:0]  d_wbrd;

  int checks = 0;
  int errors = 0;
  wb_exp_t q32[$];
  wb_exp_t q64[$];
  int ready_delay = 0, resp_delay = 0, rdy_wait = 0, resp_left = 0;
  logic use64 = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .REG_IDX_W(5), .RESULT_SRC_W(2), .STORE_WAIT_RESP(0)) dut32 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid32), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result[31:0]),
    .ex_write_data(ex_write_data[31:0]), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_result_src(ex_result_src), .stall_m(s_stall), .alu_result_m(s_alu_m),
    .misaligned_m(s_mis), .dmem_req_valid(s_rqv), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(s_addr), .dmem_we(s_we), .dmem_wstrb(s_strb), .dmem_wdata(s_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata[31:0]), .wb_valid(s_wbv),
    .wb_reg_write(s_wbrw), .wb_result_src(s_wbsrc), .wb_rd(s_wbrd),
    .wb_alu_result(s_wbalu), .wb_read_data(s_wbdata));

  mem_access_unit #(.XLEN(64), .REG_IDX_W(5), .RESULT_SRC_W(2), .STORE_WAIT_RESP(1)) dut64 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid64), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
    .ex_write_data(ex_write_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_result_src(ex_result_src), .stall_m(d_stall), .alu_result_m(d_alu_m),
    .misaligned_m(d_mis), .dmem_req_valid(d_rqv), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(d_addr), .dmem_we(d_we), .dmem_wstrb(d_strb), .dmem_wdata(d_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata), .wb_valid(d_wbv),
    .wb_reg_write(d_wbrw), .wb_result_src(d_wbsrc), .wb_rd(d_wbrd),
    .wb_alu_result(d_wbalu), .wb_read_data(d_wbdata));

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wb(input logic wide, input logic [63:0] alu, input logic [63:0] data,
                           input logic [4:0] rd, input logic rw, input logic [1:0] src);
    wb_exp_t e;
    e.alu = alu; e.data = data; e.rd = rd; e.rw = rw; e.src = src;
    if (wide) q64.push_back(e);
    else q32.push_back(e);
  endtask

  // Presents one instruction, holds it while stall_m is high, checks the request bus.
  task automatic apply_stimulus(input logic wide, input logic mr, input logic mw,
                                input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wd, input logic [4:0] rd, input logic rw,
                                input logic [1:0] src, input logic [63:0] exp_addr,
                                input logic [63:0] exp_wdata, input logic [7:0] exp_strb,
                                input logic exp_we, output int stall_cycles, output int req_cycles);
    ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3; ex_alu_result = addr;
    ex_write_data = wd; ex_rd = rd; ex_reg_write = rw; ex_result_src = src;
    use64 = wide;
    if (wide) ex_valid64 = 1'b1;
    else ex_valid32 = 1'b1;
    stall_cycles = 0;
    req_cycles = 0;
    #1;
    check_output("alu_result_m", wide ? d_alu_m : {32'd0, s_alu_m}, wide ? addr : {32'd0, addr[31:0]});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wide ? d_rqv : s_rqv) begin
        req_cycles++;
        check_output("req_addr", wide ? d_addr : {32'd0, s_addr}, exp_addr);
        check_output("req_wdata", wide ? d_wdata : {32'd0, s_wdata}, exp_wdata);
        check_output("req_wstrb", wide ? {56'd0, d_strb} : {60'd0, s_strb}, {56'd0, exp_strb});
        check_output("req_we", {63'd0, wide ? d_we : s_we}, {63'd0, exp_we});
      end
      if (wide ? d_stall : s_stall) stall_cycles++;
      else break;
    end
    @(posedge clk); #1;
    ex_valid32 = 1'b0;
    ex_valid64 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q32.size() + q64.size()) > 0; i++) @(negedge clk);
    check_output("wb_drain", 64'(q32.size() + q64.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Memory model: ready after ready_delay cycles of valid, response resp_delay after handshake.
  initial begin
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    forever begin
      @(posedge clk); #2;
      dmem_req_ready = 1'b0;
      dmem_resp_valid = 1'b0;
      if (use64 ? d_rqv : s_rqv) begin
        if (rdy_wait < ready_delay) rdy_wait++;
        else begin
          dmem_req_ready = 1'b1;
          rdy_wait = 0;
          if (resp_delay == 0) dmem_resp_valid = 1'b1;
          else resp_left = resp_delay;
        end
      end else if (resp_left > 0) begin
        resp_left--;
        if (resp_left == 0) dmem_resp_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : mon32
    wb_exp_t e;
    if (!rst && s_wbv) begin
      if (q32.size() == 0) check_output("wb32_unexpected", {63'd0, s_wbv}, 64'd0);
      else begin
        e = q32.pop_front();
        check_output("wb32_alu", {32'd0, s_wbalu}, e.alu);
        check_output("wb32_data", {32'd0, s_wbdata}, e.data);
        check_output("wb32_rd", {59'd0, s_wbrd}, {59'd0, e.rd});
        check_output("wb32_rw", {63'd0, s_wbrw}, {63'd0, e.rw});
        check_output("wb32_src", {62'd0, s_wbsrc}, {62'd0, e.src});
      end
    end
  end

  always @(negedge clk) begin : mon64
    wb_exp_t e;
    if (!rst && d_wbv) begin
      if (q64.size() == 0) check_output("wb64_unexpected", {63'd0, d_wbv}, 64'd0);
      else begin
        e = q64.pop_front();
        check_output("wb64_alu", d_wbalu, e.alu);
        check_output("wb64_data", d_wbdata, e.data);
        check_output("wb64_rd", {59'd0, d_wbrd}, {59'd0, e.rd});
        check_output("wb64_rw", {63'd0, d_wbrw}, {63'd0, e.rw});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st, rq;
    rst = 1'b1; ex_valid32 = 1'b0; ex_valid64 = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = '0; ex_alu_result = '0; ex_write_data = '0; ex_rd = '0; ex_reg_write = 1'b0;
    ex_result_src = '0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check_output("rst_req_valid", {63'd0, s_rqv}, 64'd0);
    check_output("rst_we", {63'd0, s_we}, 64'd0);
    check_output("rst_wstrb", {60'd0, s_strb}, 64'd0);
    check_output("rst_misaligned", {63'd0, s_mis}, 64'd0);
    check_output("rst_wb_valid", {63'd0, s_wbv}, 64'd0);
    check_output("rst_wb_fields", {s_wbalu, 25'd0, s_wbrw, s_wbsrc, s_wbrd}, 64'd0);
    check_output("rst_wb_data", {32'd0, s_wbdata}, 64'd0);
    check_output("rst64_outputs", {60'd0, d_rqv, d_we, d_wbv, d_mis}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Non-memory op passes through with latency 1 and never stalls.
    expect_wb(1'b0, 64'h1234, 64'h0, 5'd5, 1'b1, 2'd2);
    apply_stimulus(1'b0, 1'b0, 1'b0, F3_W, 64'h1234, 64'h0, 5'd5, 1'b1, 2'd2,
                   64'h0, 64'h0, 8'h0, 1'b0, st, rq);
    check_output("nonmem_stall", 64'(st), 64'd0);
    drain();

    // lb at 0x103, ready and response in the same cycle.
    ready_delay = 0; resp_delay = 0; dmem_rdata = 64'h80FF_0000;
    expect_wb(1'b0, 64'h103, 64'hFFFF_FF80, 5'd6, 1'b1, 2'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, F3_B, 64'h103, 64'h0, 5'd6, 1'b1, 2'd1,
                   64'h100, 64'h0, 8'h0, 1'b0, st, rq);
    check_output("lb_stall", 64'(st), 64'd1);
    check_output("lb_req_cycles", 64'(rq), 64'd1);
    drain();

    // sh 0xABCD at 0x202, ready held off 3 cycles.
    ready_delay = 3;
    expect_wb(1'b0, 64'h202, 64'h0, 5'd0, 1'b0, 2'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, F3_H, 64'h202, 64'hABCD, 5'd0, 1'b0, 2'd0,
                   64'h200, 64'hABCD_0000, 8'hC, 1'b1, st, rq);
    check_output("sh_stall", 64'(st), 64'd4);
    check_output("sh_req_cycles", 64'(rq), 64'd4);
    drain();

    // lh at 0x2, one-cycle ready delay, response two cycles after handshake.
    ready_delay = 1; resp_delay = 2; dmem_rdata = 64'h8001_0000;
    expect_wb(1'b0, 64'h2, 64'hFFFF_8001, 5'd7, 1'b1, 2'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, F3_H, 64'h2, 64'h0, 5'd7, 1'b1, 2'd0,
                   64'h0, 64'h0, 8'h0, 1'b0, st, rq);
    check_output("lh_stall", 64'(st), 64'd4);
    check_output("lh_req_cycles", 64'(rq), 64'd2);
    drain();

    // lbu with both read and write set behaves as a load.
    ready_delay = 0; resp_delay = 0; dmem_rdata = 64'h0000_F000;
    expect_wb(1'b0, 64'h101, 64'hF0, 5'd9, 1'b1, 2'd1);
    apply_stimulus(1'b0, 1'b1, 1'b1, F3_BU, 64'h101, 64'hFFFF_FFFF, 5'd9, 1'b1, 2'd1,
                   64'h100, 64'h0, 8'h0, 1'b0, st, rq);
    check_output("lbu_stall", 64'(st), 64'd1);
    drain();

    // sb into the top lane.
    expect_wb(1'b0, 64'h3, 64'h0, 5'd0, 1'b0, 2'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, F3_B, 64'h3, 64'h1122_335A, 5'd0, 1'b0, 2'd0,
                   64'h0, 64'h5A00_0000, 8'h8, 1'b1, st, rq);
    check_output("sb_req_cycles", 64'(rq), 64'd1);
    drain();

    // Misaligned lw and unsupported ld on the 32-bit instance.
    expect_wb(1'b0, 64'h301, 64'h0, 5'd4, 1'b0, 2'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, F3_W, 64'h301, 64'h0, 5'd4, 1'b1, 2'd0,
                   64'h0, 64'h0, 8'h0, 1'b0, st, rq);
    check_output("mis_stall", 64'(st), 64'd0);
    @(negedge clk);
    check_output("mis_pulse", {63'd0, s_mis}, 64'd1);
    check_output("mis_no_req", {63'd0, s_rqv}, 64'd0);
    @(negedge clk);
    check_output("mis_one_cycle", {63'd0, s_mis}, 64'd0);
    drain();
    expect_wb(1'b0, 64'h0, 64'h0, 5'd3, 1'b0, 2'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, F3_D, 64'h0, 64'h0, 5'd3, 1'b1, 2'd0,
                   64'h0, 64'h0, 8'h0, 1'b0, st, rq);
    check_output("ld32_req_cycles", 64'(rq), 64'd0);
    @(negedge clk);
    check_output("ld32_mis_pulse", {63'd0, s_mis}, 64'd1);
    drain();

    // lhu at 0x400, reset while waiting for the response; late response ignored.
    ready_delay = 0; resp_delay = 5; dmem_rdata = 64'h1234_5678;
    ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = F3_HU; ex_alu_result = 64'h400;
    ex_rd = 5'd8; ex_reg_write = 1'b1; use64 = 1'b0; ex_valid32 = 1'b1;
    @(negedge clk);
    check_output("rstop_stall_idle", {63'd0, s_stall}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("rstop_req", {63'd0, s_rqv}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; ex_valid32 = 1'b0; #1;
    check_output("rstop_stall", {63'd0, s_stall}, 64'd0);
    check_output("rstop_outputs", {s_addr, 25'd0, s_rqv, s_we, s_wbv, s_strb}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("rstop_quiet", {62'd0, s_wbv, s_rqv}, 64'd0);
    end
    @(posedge clk); #1;

    // 64-bit ld, lw sign extension, and a store completing on the response.
    ready_delay = 0; resp_delay = 0; dmem_rdata = 64'h8000_0000_0000_0001;
    expect_wb(1'b1, 64'h8, 64'h8000_0000_0000_0001, 5'd10, 1'b1, 2'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0, F3_D, 64'h8, 64'h0, 5'd10, 1'b1, 2'd0,
                   64'h8, 64'h0, 8'h0, 1'b0, st, rq);
    check_output("ld64_stall", 64'(st), 64'd1);
    drain();
    dmem_rdata = 64'h8000_0001_0000_0000;
    expect_wb(1'b1, 64'h4, 64'hFFFF_FFFF_8000_0001, 5'd11, 1'b1, 2'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0, F3_W, 64'h4, 64'h0, 5'd11, 1'b1, 2'd0,
                   64'h0, 64'h0, 8'h0, 1'b0, st, rq);
    check_output("lw64_req_cycles", 64'(rq), 64'd1);
    drain();
    resp_delay = 2;
    expect_wb(1'b1, 64'h14, 64'h0, 5'd0, 1'b0, 2'd0);
    apply_stimulus(1'b1, 1'b0, 1'b1, F3_W, 64'h14, 64'hDEAD_BEEF, 5'd0, 1'b0, 2'd0,
                   64'h10, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1, st, rq);
    check_output("sw64_stall", 64'(st), 64'd3);
    check_output("sw64_req_cycles", 64'(rq), 64'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
